// File: rtl/spu_res_add_if.sv
// gbuf read/write port of the SPU residual-add stage.
// master = residual-add block, slave = gbuf.
interface spu_res_add_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  add_gbuf_ren;
    logic [ADDR_WIDTH-1:0] add_gbuf_raddr;
    logic [DATA_WIDTH-1:0] add_gbuf_rdata;
    logic                  add_gbuf_wen;
    logic [ADDR_WIDTH-1:0] add_gbuf_waddr;
    logic [DATA_WIDTH-1:0] add_gbuf_wdata;

    modport master (
        output add_gbuf_ren, add_gbuf_raddr, add_gbuf_wen, add_gbuf_waddr, add_gbuf_wdata,
        input  add_gbuf_rdata
    );
    modport slave (
        input  add_gbuf_ren, add_gbuf_raddr, add_gbuf_wen, add_gbuf_waddr, add_gbuf_wdata,
        output add_gbuf_rdata
    );
endinterface

// File: rtl/spu_res_add.sv
// SPU residual-add pre-stage: out = (A + B) >>> add_shift per int8 lane, row-aligned into gbuf.
// Define SPU_RES_ADD_SAT_EN to clamp lanes to int8; otherwise lanes wrap to their low 8 bits.

module spu_res_add_lane (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] shift,
    output logic [7:0] y
);
    logic signed [8:0] sum;
    logic signed [8:0] shd;

    assign sum = $signed({a[7], a}) + $signed({b[7], b});
    assign shd = sum >>> shift;
`ifdef SPU_RES_ADD_SAT_EN
    always_comb begin
        if (shd > 9'sd127)       y = 8'h7f;
        else if (shd < -9'sd128) y = 8'h80;
        else                     y = shd[7:0];
    end
`else
    assign y = 8'(shd);
`endif
endmodule

module spu_res_add #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int RLATENCY   = 1
) (
    input  logic                  core_clk,
    input  logic                  rst_n,
    input  logic                  add_start,
    output logic                  add_end,
    input  logic [ADDR_WIDTH-1:0] spu_matrix_y,
    input  logic [ADDR_WIDTH-1:0] spu_matrix_x,
    input  logic [ADDR_WIDTH-1:0] a_base_addr,
    input  logic [ADDR_WIDTH-1:0] b_base_addr,
    input  logic [ADDR_WIDTH-1:0] om_base_addr,
    input  logic [ADDR_WIDTH-1:0] a_addr_align,
    input  logic [ADDR_WIDTH-1:0] b_addr_align,
    input  logic [ADDR_WIDTH-1:0] ofm_addr_align,
    input  logic [2:0]            add_shift,
    spu_res_add_if.master         gbuf
);
    localparam int NUM_LANES = DATA_WIDTH / 8;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic                  phase_q, phase_d;
    addr_t                 x_q, x_d, y_q, y_d;
    addr_t                 a_al_q, a_al_d, b_al_q, b_al_d, o_al_q, o_al_d;
    logic [2:0]            shift_q, shift_d;
    addr_t                 rc_q, rc_d, rr_q, rr_d, a_row_q, a_row_d, b_row_q, b_row_d;
    addr_t                 wc_q, wc_d, wr_q, wr_d, o_row_q, o_row_d;
    logic [RLATENCY-1:0]   vld_pipe_q, vld_pipe_d, tag_pipe_q, tag_pipe_d;
    logic [DATA_WIDTH-1:0] a_lat_q, a_lat_d, wdata_q, wdata_d;
    addr_t                 waddr_q, waddr_d;
    logic                  wen_q, wen_d, end_q, end_d;

    logic                          ren, fire_a, fire_b, rd_last, w_last;
    addr_t                         x_words;
    logic [NUM_LANES-1:0][7:0]     lane_y;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        spu_res_add_lane u_lane (
            .a     (a_lat_q[l*8 +: 8]),
            .b     (gbuf.add_gbuf_rdata[l*8 +: 8]),
            .shift (shift_q),
            .y     (lane_y[l])
        );
    end

    assign x_words = spu_matrix_x >> 2;
    assign ren     = (state_q == RUN);
    assign fire_a  = vld_pipe_q[RLATENCY-1] & ~tag_pipe_q[RLATENCY-1];
    assign fire_b  = vld_pipe_q[RLATENCY-1] &  tag_pipe_q[RLATENCY-1];
    assign rd_last = phase_q && (rr_q == y_q - addr_t'(1)) && (rc_q == x_q - addr_t'(1));
    assign w_last  = (wr_q == y_q - addr_t'(1)) && (wc_q == x_q - addr_t'(1));

    assign gbuf.add_gbuf_ren    = ren;
    assign gbuf.add_gbuf_raddr  = (phase_q ? b_row_q : a_row_q) + rc_q;
    assign gbuf.add_gbuf_wen    = wen_q;
    assign gbuf.add_gbuf_waddr  = waddr_q;
    assign gbuf.add_gbuf_wdata  = wdata_q;
    assign add_end              = end_q;

    always_comb begin
        state_d = state_q;  phase_d = phase_q;
        x_d = x_q;  y_d = y_q;  a_al_d = a_al_q;  b_al_d = b_al_q;  o_al_d = o_al_q;
        shift_d = shift_q;
        rc_d = rc_q;  rr_d = rr_q;  a_row_d = a_row_q;  b_row_d = b_row_q;
        wc_d = wc_q;  wr_d = wr_q;  o_row_d = o_row_q;
        a_lat_d = a_lat_q;  wdata_d = wdata_q;  waddr_d = waddr_q;
        wen_d = 1'b0;  end_d = 1'b0;
        // Tag travels with ren so a returning word is known to be A (0) or B (1).
        vld_pipe_d = RLATENCY'({vld_pipe_q, ren});
        tag_pipe_d = RLATENCY'({tag_pipe_q, phase_q});

        case (state_q)
            IDLE: if (add_start) begin
                x_d = x_words;  y_d = spu_matrix_y;
                a_al_d = a_addr_align;  b_al_d = b_addr_align;  o_al_d = ofm_addr_align;
                shift_d = add_shift;
                a_row_d = a_base_addr;  b_row_d = b_base_addr;  o_row_d = om_base_addr;
                rc_d = '0;  rr_d = '0;  wc_d = '0;  wr_d = '0;  phase_d = 1'b0;
                state_d = (x_words == '0 || spu_matrix_y == '0) ? DONE : RUN;
            end
            RUN: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (rc_q == x_q - addr_t'(1)) begin
                        rc_d = '0;
                        rr_d = rr_q + addr_t'(1);
                        a_row_d = a_row_q + a_al_q;
                        b_row_d = b_row_q + b_al_q;
                    end else begin
                        rc_d = rc_q + addr_t'(1);
                    end
                end
                if (rd_last) state_d = DRAIN;
            end
            DRAIN: if (fire_b && w_last) state_d = DONE;
            DONE: begin
                end_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (fire_a) a_lat_d = gbuf.add_gbuf_rdata;
        if (fire_b) begin
            wen_d   = 1'b1;
            wdata_d = lane_y;
            waddr_d = o_row_q + wc_q;
            if (wc_q == x_q - addr_t'(1)) begin
                wc_d = '0;
                wr_d = wr_q + addr_t'(1);
                o_row_d = o_row_q + o_al_q;
            end else begin
                wc_d = wc_q + addr_t'(1);
            end
        end
    end

    always_ff @(posedge core_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;  phase_q <= 1'b0;
            x_q <= '0;  y_q <= '0;  a_al_q <= '0;  b_al_q <= '0;  o_al_q <= '0;
            shift_q <= '0;
            rc_q <= '0;  rr_q <= '0;  a_row_q <= '0;  b_row_q <= '0;
            wc_q <= '0;  wr_q <= '0;  o_row_q <= '0;
            vld_pipe_q <= '0;  tag_pipe_q <= '0;
            a_lat_q <= '0;  wdata_q <= '0;  waddr_q <= '0;
            wen_q <= 1'b0;  end_q <= 1'b0;
        end else begin
            state_q <= state_d;  phase_q <= phase_d;
            x_q <= x_d;  y_q <= y_d;  a_al_q <= a_al_d;  b_al_q <= b_al_d;  o_al_q <= o_al_d;
            shift_q <= shift_d;
            rc_q <= rc_d;  rr_q <= rr_d;  a_row_q <= a_row_d;  b_row_q <= b_row_d;
            wc_q <= wc_d;  wr_q <= wr_d;  o_row_q <= o_row_d;
            vld_pipe_q <= vld_pipe_d;  tag_pipe_q <= tag_pipe_d;
            a_lat_q <= a_lat_d;  wdata_q <= wdata_d;  waddr_q <= waddr_d;
            wen_q <= wen_d;  end_q <= end_d;
        end
    end
endmodule

// File: tb/tb_spu_res_add.sv
// Directed bench for spu_res_add: lane-math vector table plus geometry, zero-size,
// RLATENCY=3 and mid-run reset sequences against a behavioural gbuf.
module tb_spu_res_add;
    logic        core_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0, start3 = 1'b0;
    logic        end1, end3;
    logic [11:0] cfg_y = '0, cfg_x = '0, ab = '0, bb = '0, ob = '0, aal = '0, bal = '0, oal = '0;
    logic [2:0]  sh = '0;
    logic        sel = 1'b0;
    logic [31:0] mem [0:4095];
    logic [31:0] rp1;
    logic [31:0] rp3 [0:2];
    int          cyc = 0, t0 = 0, n_vec = 0, n_bad = 0;

    int          r_cyc[$], w_cyc[$], e_cyc[$];
    logic [11:0] r_addr[$], w_addr[$];
    logic [31:0] w_data[$];

    typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] sh; logic [31:0] exp; } vec_t;
    vec_t vecs[6];

    spu_res_add_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus1 ();
    spu_res_add_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus3 ();

    spu_res_add #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RLATENCY(1)) u_dut1 (
        .core_clk(core_clk), .rst_n(rst_n), .add_start(start1), .add_end(end1),
        .spu_matrix_y(cfg_y), .spu_matrix_x(cfg_x), .a_base_addr(ab), .b_base_addr(bb),
        .om_base_addr(ob), .a_addr_align(aal), .b_addr_align(bal), .ofm_addr_align(oal),
        .add_shift(sh), .gbuf(bus1));
    spu_res_add #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .RLATENCY(3)) u_dut3 (
        .core_clk(core_clk), .rst_n(rst_n), .add_start(start3), .add_end(end3),
        .spu_matrix_y(cfg_y), .spu_matrix_x(cfg_x), .a_base_addr(ab), .b_base_addr(bb),
        .om_base_addr(ob), .a_addr_align(aal), .b_addr_align(bal), .ofm_addr_align(oal),
        .add_shift(sh), .gbuf(bus3));

    always #5 core_clk = ~core_clk;

    // Behavioural gbuf read ports with latency 1 and 3.
    always @(posedge core_clk) begin
        cyc    <= cyc + 1;
        rp1    <= mem[bus1.add_gbuf_raddr];
        rp3[0] <= mem[bus3.add_gbuf_raddr];
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign bus1.add_gbuf_rdata = rp1;
    assign bus3.add_gbuf_rdata = rp3[2];

    logic        m_ren, m_wen, m_end;
    logic [11:0] m_raddr, m_waddr;
    logic [31:0] m_wdata;
    assign m_ren   = sel ? bus3.add_gbuf_ren   : bus1.add_gbuf_ren;
    assign m_raddr = sel ? bus3.add_gbuf_raddr : bus1.add_gbuf_raddr;
    assign m_wen   = sel ? bus3.add_gbuf_wen   : bus1.add_gbuf_wen;
    assign m_waddr = sel ? bus3.add_gbuf_waddr : bus1.add_gbuf_waddr;
    assign m_wdata = sel ? bus3.add_gbuf_wdata : bus1.add_gbuf_wdata;
    assign m_end   = sel ? end3 : end1;

    always @(negedge core_clk) begin
        if (m_ren) begin r_cyc.push_back(cyc - t0); r_addr.push_back(m_raddr); end
        if (m_wen) begin w_cyc.push_back(cyc - t0); w_addr.push_back(m_waddr); w_data.push_back(m_wdata); end
        if (m_end) e_cyc.push_back(cyc - t0);
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a, input logic [31:0] b, input int shv);
        logic [31:0] r;
        int s;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            s = int'($signed(a[l*8 +: 8])) + int'($signed(b[l*8 +: 8]));
            s = s >>> shv;
`ifdef SPU_RES_ADD_SAT_EN
            if (s > 127) s = 127;
            if (s < -128) s = -128;
`endif
            r[l*8 +: 8] = s[7:0];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        r_cyc.delete(); r_addr.delete(); w_cyc.delete(); w_addr.delete(); w_data.delete(); e_cyc.delete();
    endtask

    task automatic run_job(input logic s, input logic [11:0] y, input logic [11:0] x, input int restart_at);
        @(negedge core_clk);
        sel = s; cfg_y = y; cfg_x = x;
        clear_logs();
        t0 = cyc;
        if (s) start3 = 1'b1; else start1 = 1'b1;
        for (int k = 1; k < 300; k++) begin
            @(negedge core_clk); #1;
            start1 = (!s && k == restart_at);
            start3 = ( s && k == restart_at);
            if (e_cyc.size() != 0) break;
        end
        start1 = 1'b0; start3 = 1'b0;
        repeat (4) @(negedge core_clk);
        #1;
    endtask

    task automatic check_geom(input string tag);
        int exp_r[8];
        int exp_w[4];
        exp_r = '{'h000, 'h100, 'h001, 'h101, 'h008, 'h108, 'h009, 'h109};
        exp_w = '{'h200, 'h201, 'h208, 'h209};
        chk({tag, "_nreads"}, r_addr.size(), 8);
        for (int i = 0; i < 8; i++)
            chk({tag, "_raddr"}, (i < r_addr.size()) ? 32'(r_addr[i]) : 32'hdead, exp_r[i]);
        chk({tag, "_nwrites"}, w_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_waddr"}, (i < w_addr.size()) ? 32'(w_addr[i]) : 32'hdead, exp_w[i]);
            chk({tag, "_wdata"}, (i < w_data.size()) ? w_data[i] : 32'hdeadbeef,
                ref_word(mem[exp_r[2*i]], mem[exp_r[2*i+1]], 0));
        end
        chk({tag, "_nend"}, e_cyc.size(), 1);
        chk({tag, "_end_cyc"}, (e_cyc.size() > 0) ? e_cyc[0] : -1, 11);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        vecs[0] = '{32'h01020304, 32'h10101010, 3'd0, 32'h11121314};
`ifdef SPU_RES_ADD_SAT_EN
        vecs[1] = '{32'h0000807F, 32'h0000807F, 3'd0, 32'h0000807F};
`else
        vecs[1] = '{32'h0000807F, 32'h0000807F, 3'd0, 32'h000000FE};
`endif
        vecs[2] = '{32'h0000007F, 32'h00000001, 3'd1, 32'h00000040};
        vecs[3] = '{32'hFFFEF005, 32'h01FEF0FB, 3'd0, 32'h00FCE000};
        vecs[4] = '{32'h7F7F7F80, 32'h7F7F7F80, 3'd7, 32'h010101FE};
        vecs[5] = '{32'h000000C0, 32'h000000C1, 3'd2, 32'h000000E0};

        #1;
        chk("rst_ren",   bus1.add_gbuf_ren, 0);
        chk("rst_wen",   bus1.add_gbuf_wen, 0);
        chk("rst_end",   end1, 0);
        chk("rst_raddr", bus1.add_gbuf_raddr, 0);
        chk("rst_waddr", bus1.add_gbuf_waddr, 0);
        chk("rst_wdata", bus1.add_gbuf_wdata, 0);
        repeat (3) @(negedge core_clk);
        rst_n = 1'b1;

        // Lane arithmetic, single-word job
        ab = 12'h000; bb = 12'h100; ob = 12'h200; aal = 4; bal = 4; oal = 4;
        for (int v = 0; v < 6; v++) begin
            mem[0] = vecs[v].a; mem['h100] = vecs[v].b; sh = vecs[v].sh;
            run_job(1'b0, 12'd1, 12'd4, 0);
            chk("vec_nwrites", w_data.size(), 1);
            chk("vec_wdata", (w_data.size() > 0) ? w_data[0] : 32'hdeadbeef, vecs[v].exp);
            if (v == 0) begin
                chk("t_rd_a_cyc", (r_cyc.size() > 0) ? r_cyc[0] : -1, 1);
                chk("t_rd_b_cyc", (r_cyc.size() > 1) ? r_cyc[1] : -1, 2);
                chk("t_wr_cyc",   (w_cyc.size() > 0) ? w_cyc[0] : -1, 4);
                chk("t_waddr",    (w_addr.size() > 0) ? 32'(w_addr[0]) : 32'hdead, 'h200);
                chk("t_end_cyc",  (e_cyc.size() > 0) ? e_cyc[0] : -1, 5);
            end
        end

        // Geometry with a restart pulse in RUN that must be ignored
        aal = 8; bal = 8; oal = 8; sh = 0;
        mem['h000] = 32'h01020304; mem['h001] = 32'h11F0807F; mem['h008] = 32'hA5A5A5A5; mem['h009] = 32'h00000001;
        mem['h100] = 32'h10101010; mem['h101] = 32'h22108081; mem['h108] = 32'h5A5A5A5A; mem['h109] = 32'h7F7F7F7F;
        run_job(1'b0, 12'd2, 12'd8, 3);
        check_geom("geom");

        // Zero-size jobs
        run_job(1'b0, 12'd1, 12'd3, 0);
        chk("zx_nreads", r_cyc.size(), 0);
        chk("zx_nwrites", w_cyc.size(), 0);
        chk("zx_end_cyc", (e_cyc.size() > 0) ? e_cyc[0] : -1, 2);
        run_job(1'b0, 12'd0, 12'd8, 0);
        chk("zy_nreads", r_cyc.size(), 0);
        chk("zy_nwrites", w_cyc.size(), 0);
        chk("zy_end_cyc", (e_cyc.size() > 0) ? e_cyc[0] : -1, 2);

        // RLATENCY=3, 3x5 words, shift 1
        sh = 3'd1;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) begin
                mem[r*8 + c]         = 32'h7F80C001 ^ (32'(r*5 + c) * 32'h1D2B3C4F);
                mem['h100 + r*8 + c] = 32'h017FF0FF ^ (32'(r*5 + c) * 32'h0B163A55);
            end
        run_job(1'b1, 12'd3, 12'd20, 0);
        chk("rl3_nwrites", w_data.size(), 15);
        chk("rl3_first_wr", (w_cyc.size() > 0) ? w_cyc[0] : -1, 6);
        chk("rl3_last_wr",  (w_cyc.size() > 14) ? w_cyc[14] : -1, 34);
        chk("rl3_end_cyc",  (e_cyc.size() > 0) ? e_cyc[0] : -1, 35);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) begin
                chk("rl3_waddr", (r*5+c < w_addr.size()) ? 32'(w_addr[r*5+c]) : 32'hdead, 'h200 + r*8 + c);
                chk("rl3_wdata", (r*5+c < w_data.size()) ? w_data[r*5+c] : 32'hdeadbeef,
                    ref_word(mem[r*8 + c], mem['h100 + r*8 + c], 1));
            end

        // Reset mid-RUN, then a clean rerun of the geometry job
        sh = 0;
        @(negedge core_clk);
        sel = 1'b0; cfg_y = 12'd2; cfg_x = 12'd8;
        clear_logs();
        t0 = cyc;
        start1 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge core_clk); #1;
            start1 = 1'b0;
        end
        chk("mid_pre_wen", bus1.add_gbuf_wen, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ren", bus1.add_gbuf_ren, 0);
        chk("mid_wen", bus1.add_gbuf_wen, 0);
        chk("mid_end", end1, 0);
        repeat (3) @(negedge core_clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (6) @(negedge core_clk);
        #1;
        chk("post_rst_nreads", r_cyc.size(), 0);
        chk("post_rst_nwrites", w_cyc.size(), 0);
        run_job(1'b0, 12'd2, 12'd8, 0);
        check_geom("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
